// File: rtl/alu_result_collector.sv
// Reassembles the ALU byte-serial result stream into 32-bit words, classifies
// each word, and buffers it in a first-word-fall-through FIFO for the host.
module alu_result_collector #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            alu_out,
  input  logic                  alu_done,
  input  logic                  res_ready,
  output logic                  res_valid,
  output logic [31:0]           res_data,
  output logic [3:0]            res_flags,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  frame_err,
  output logic                  ovf_err,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, B1, B2, B3} asm_state_t;

  asm_state_t        state;
  logic [23:0]       asm_buf;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       mem_data  [DEPTH];
  logic [3:0]        mem_flags [DEPTH];

  logic        push;
  logic        pop;
  logic        full;
  logic        accept;
  logic        ovf_event;
  logic        frame_event;
  logic [31:0] word;
  logic [3:0]  word_flags;
  logic [7:0]  word_exp;
  logic [22:0] word_man;

  always_comb begin
    word        = {alu_out, asm_buf};
    word_exp    = word[30:23];
    word_man    = word[22:0];
    word_flags  = '0;
    word_flags[3] = (word_exp == 8'hFF) && (word_man != '0);
    word_flags[2] = (word_exp == 8'hFF) && (word_man == '0);
    word_flags[1] = (word_exp == 8'h00) && (word_man == '0);
    word_flags[0] = word[31];
  end

  // A full FIFO still accepts the push when the head is popped in the same cycle.
  always_comb begin
    push        = (state == B3) && alu_done;
    frame_event = (state != IDLE) && !alu_done;
    full        = (level == LVL_W'(DEPTH));
    pop         = (level != '0) && res_ready;
    accept      = push && (!full || pop);
    ovf_event   = push && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      asm_buf   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (alu_done) begin
        case (state)
          IDLE: begin asm_buf[7:0]   <= alu_out; state <= B1; end
          B1:   begin asm_buf[15:8]  <= alu_out; state <= B2; end
          B2:   begin asm_buf[23:16] <= alu_out; state <= B3; end
          default: state <= IDLE;
        endcase
      end else begin
        state <= IDLE;
      end

      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

      if (accept && !pop)      level <= level + LVL_W'(1);
      else if (pop && !accept) level <= level - LVL_W'(1);

      frame_err <= (frame_err && !clr_err) || frame_event;
      ovf_err   <= (ovf_err && !clr_err) || ovf_event;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr]  <= word;
      mem_flags[wr_ptr] <= word_flags;
    end
  end

  // Storage has no reset; gating on valid keeps outputs zero while empty.
  always_comb begin
    res_valid = (level != '0);
    res_data  = res_valid ? mem_data[rd_ptr]  : '0;
    res_flags = res_valid ? mem_flags[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_alu_result_collector;

  localparam int DL2   = 2;
  localparam int DEPTH = 2 ** DL2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    alu_out;
  logic          alu_done;
  logic          res_ready;
  logic          res_valid;
  logic [31:0]   res_data;
  logic [3:0]    res_flags;
  logic [DL2:0]  level;
  logic          frame_err;
  logic          ovf_err;
  logic          clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_collector #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_done(alu_done),
    .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
    .res_flags(res_flags), .level(level), .frame_err(frame_err),
    .ovf_err(ovf_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] classify(input logic [31:0] w);
    int unsigned e, m;
    e = (w >> 23) & 32'hFF;
    m = w & 32'h7FFFFF;
    return {(e == 255 && m != 0), (e == 255 && m == 0), (e == 0 && m == 0), w[31]};
  endfunction

  // Reference model: a byte list and a word queue.
  logic [31:0] mq[$];
  logic [31:0] acc;
  int          nb;
  logic        m_fe, m_oe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      nb = 0; acc = '0; m_fe = 1'b0; m_oe = 1'b0;
    end else begin
      logic popped, have, fev, oev;
      popped = (mq.size() != 0) && res_ready;
      have = 1'b0; fev = 1'b0; oev = 1'b0;
      if (alu_done) begin
        acc[nb*8 +: 8] = alu_out;
        nb++;
        if (nb == 4) begin have = 1'b1; nb = 0; end
      end else if (nb != 0) begin
        fev = 1'b1; nb = 0;
      end
      if (popped) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(acc);
        else oev = 1'b1;
      end
      m_fe = (m_fe && !clr_err) || fev;
      m_oe = (m_oe && !clr_err) || oev;
    end
  end

  always @(posedge clk) begin
    #1;
    check("valid", 32'(res_valid), 32'(mq.size() != 0));
    check("level", 32'(level), 32'(mq.size()));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("ovf_err", 32'(ovf_err), 32'(m_oe));
    if (mq.size() != 0) begin
      check("data", res_data, mq[0]);
      check("flags", 32'(res_flags), 32'(classify(mq[0])));
    end
  end

  task automatic cyc(input logic d, input logic [7:0] b, input logic rdy, input logic clr);
    @(negedge clk);
    alu_done = d; alu_out = b; res_ready = rdy; clr_err = clr;
  endtask

  task automatic frame(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, w[i*8 +: 8], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] w5;
    rst = 1'b1; alu_done = 1'b0; alu_out = '0; res_ready = 1'b0; clr_err = 1'b0;
    #1;
    check("rst_valid", 32'(res_valid), 0);
    check("rst_data", res_data, 0);
    check("rst_level", 32'(level), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single frame
    frame(32'h40400000, 1'b0);
    idle(1, 1'b0);
    check("single_valid", 32'(res_valid), 1);
    check("single_data", res_data, 32'h40400000);
    check("single_flags", 32'(res_flags), 32'h0);
    check("single_level", 32'(level), 1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("single_popped_valid", 32'(res_valid), 0);
    check("single_popped_level", 32'(level), 0);

    // Classification
    frame(32'hFF800000, 1'b0);
    frame(32'h7FC00000, 1'b0);
    frame(32'h80000000, 1'b0);
    frame(32'h00000001, 1'b0);
    idle(1, 1'b0);
    check("cls_ninf", 32'(res_flags), 32'h5);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("cls_nan", 32'(res_flags), 32'h8);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("cls_negzero", 32'(res_flags), 32'h3);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("cls_denorm", 32'(res_flags), 32'h0);
    check("cls_denorm_data", res_data, 32'h00000001);
    idle(2, 1'b1);

    // Back-to-back frames
    frame(32'h3F800000, 1'b0);
    frame(32'hC0000000, 1'b0);
    idle(1, 1'b0);
    check("b2b_level", 32'(level), 2);
    check("b2b_first", res_data, 32'h3F800000);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("b2b_second", res_data, 32'hC0000000);
    idle(2, 1'b1);

    // Overflow without pop
    for (int k = 0; k < 5; k++) frame(32'h41000000 + 32'(k), 1'b0);
    idle(1, 1'b0);
    check("ovf_level", 32'(level), 4);
    check("ovf_flag", 32'(ovf_err), 1);
    check("ovf_head", res_data, 32'h41000000);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("ovf_cleared", 32'(ovf_err), 0);
    idle(5, 1'b1);

    // Full with simultaneous pop on the push edge
    for (int k = 0; k < 4; k++) frame(32'h42000000 + 32'(k), 1'b0);
    w5 = 32'h42000004;
    for (int i = 0; i < 3; i++) cyc(1'b1, w5[i*8 +: 8], 1'b0, 1'b0);
    cyc(1'b1, w5[31:24], 1'b1, 1'b0);
    idle(1, 1'b0);
    check("ovf_pop_level", 32'(level), 4);
    check("ovf_pop_flag", 32'(ovf_err), 0);
    check("ovf_pop_head", res_data, 32'h42000001);
    idle(5, 1'b1);

    // Truncated frame
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b0);
    check("trunc_err", 32'(frame_err), 1);
    check("trunc_level", 32'(level), 0);
    frame(32'h12345678, 1'b0);
    idle(1, 1'b0);
    check("trunc_next", res_data, 32'h12345678);
    idle(2, 1'b1);

    // Async reset mid-frame with two words queued
    frame(32'h11111111, 1'b0);
    frame(32'h22222222, 1'b0);
    cyc(1'b1, 8'hEF, 1'b0, 1'b0);
    cyc(1'b1, 8'hBE, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(res_valid), 0);
    check("arst_data", res_data, 0);
    check("arst_flags", 32'(res_flags), 0);
    check("arst_level", 32'(level), 0);
    check("arst_fe", 32'(frame_err), 0);
    check("arst_oe", 32'(ovf_err), 0);
    alu_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame(32'hDEADBEEF, 1'b0);
    idle(1, 1'b0);
    check("post_rst_data", res_data, 32'hDEADBEEF);
    check("post_rst_level", 32'(level), 1);
    check("post_rst_fe", 32'(frame_err), 0);
    idle(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream consumer of the FP32 ALU byte-serial result port.
- Monitors the ALU `done`/`out` pair, reassembles each 4-byte result (LSB first) into a 32-bit word, and classifies it (NaN/Inf/zero/sign).
- Buffers words in a small FIFO and presents them to the host/readback logic over a valid/ready handshake.
- Detects truncated frames and FIFO overflow.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth in words. Depth = 2**DEPTH_LOG2; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- alu_out  input  8  result byte from ALU, valid while alu_done=1
- alu_done  input  1  ALU done strobe; high for exactly 4 consecutive cycles per result, bytes 0..3 in order
- res_ready  input  1  consumer accepts head word when res_valid=1
- res_valid  output  1  FIFO not empty
- res_data  output  32  head-of-FIFO result word
- res_flags  output  4  head-of-FIFO class: [3]=nan, [2]=inf, [1]=zero, [0]=neg
- level  output  DEPTH_LOG2+1  number of words currently stored
- frame_err  output  1  sticky: alu_done dropped before 4 bytes were captured
- ovf_err  output  1  sticky: completed word dropped because FIFO was full
- clr_err  input  1  synchronous clear of frame_err and ovf_err

Behaviour:
- Reset: asserting rst clears assembly buffer, byte counter, FIFO pointers and both sticky flags immediately. During reset: res_valid=0, res_data=0, res_flags=0, level=0, frame_err=0, ovf_err=0. Reset mid-frame discards partial bytes, with no error flagged.
- Assembly FSM states: IDLE, B1, B2, B3.
  - IDLE: alu_done=1 -> capture alu_out into bits [7:0], go to B1.
  - B1: alu_done=1 -> capture into [15:8], go to B2.
  - B2: alu_done=1 -> capture into [23:16], go to B3.
  - B3: alu_done=1 -> form the word from the buffer plus alu_out as [31:24], issue a push, go to IDLE.
  - In B1/B2/B3, alu_done=0 -> set frame_err, discard partial word, go to IDLE.
- Back-to-back frames: alu_done continuing high in the cycle after B3 is treated as byte 0 of a new frame. The counter wraps 3 -> 0 with no idle cycle required.
- Classification is computed combinationally on the completed word at push time, using e=word[30:23] and m=word[22:0]:
  - nan = (e==8'hFF && m!=0)
  - inf = (e==8'hFF && m==0)
  - zero = (e==0 && m==0); denormals are not zero
  - neg = word[31], for all classes including NaN and -0
- FIFO (first-word-fall-through):
  - res_valid = (level!=0); res_data/res_flags show the entry at the read pointer.
  - Pop occurs when res_valid && res_ready.
- Latency: a word pushed at edge N is visible with res_valid=1 after edge N, i.e. 1 cycle after byte 3 is sampled, if the FIFO was empty.
- Push when full:
  - If a pop also occurs in the same cycle, the push is accepted and level is unchanged.
  - Otherwise the word is dropped, ovf_err is set, and FIFO contents are unchanged.
- Push and pop simultaneously when not full: both occur, level unchanged.
- res_ready while empty: ignored.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. level is maintained explicitly, ranging 0..DEPTH.
- clr_err=1 clears both sticky flags at the edge. If a new error event occurs in the same cycle, the flag stays set (set wins).
- res_data must hold stable while res_valid=1 and res_ready=0.

Test Plan:
- Single frame: alu_done=1 for 4 cycles with bytes 00,00,40,40, res_ready=0 -> next cycle res_valid=1, res_data=32'h40400000, res_flags=4'b0000, level=1. Then res_ready=1 for one cycle -> res_valid=0, level=0.
- Classification: frames 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000001 -> res_flags = 4'b0101, 4'b1000, 4'b0011, 4'b0000 respectively, popped in order.
- Back-to-back: alu_done high for 8 cycles carrying 32'h3F800000 then 32'hC0000000, res_ready=0 -> level=2, words popped in that order.
- Overflow (DEPTH_LOG2=2): 5 frames with res_ready=0 -> level=4, ovf_err=1, the 5th word absent. Repeat with res_ready=1 during the 5th push -> ovf_err stays 0, level=4. Then clr_err=1 -> ovf_err=0.
- Truncated frame: alu_done high for 2 cycles then low -> frame_err=1, level unchanged. Next full frame 32'h12345678 is assembled correctly.
- Async reset mid-frame: rst pulsed after byte 1 with 2 words queued -> outputs go to 0 without waiting for a clock edge. The next frame 32'hDEADBEEF is assembled cleanly, frame_err=0.
